// File: rtl/codon_reader.sv
// Loads up to five nibble-coded codons (4'hF terminated) and presents the nibble
// of every codon at a shared index combinationally, with per-codon end flags.
module codon_reader #(
  parameter int MAX_LEN = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [3:0] i_nibble_in,
  input  logic       i_nibble_valid,
  output logic       o_nibble_ready,
  input  logic [3:0] i_codon_index,
  output logic [3:0] o_codon1,
  output logic [3:0] o_codon2,
  output logic [3:0] o_codon3,
  output logic [3:0] o_codon4,
  output logic [3:0] o_codon5,
  output logic [4:0] o_end_of_codon,
  output logic       o_done_reader,
  output logic       o_error
);

  localparam logic [3:0] MAX_LEN_4 = 4'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERROR
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_len [5];
  logic [2:0] r_cur;
  logic [3:0] r_wr_ptr;
  // Sixteen slots per codon so the 4-bit pointers index the array exactly;
  // only the first MAX_LEN slots are ever written or read.
  logic [3:0] r_store [5][16];

  logic w_accept;
  logic w_term;
  logic w_room;

  assign w_accept = (r_state == S_LOAD) && i_nibble_valid;
  assign w_term   = (i_nibble_in == 4'hF);
  assign w_room   = (r_wr_ptr < MAX_LEN_4);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_accept) begin
          if (w_term && (r_cur == 3'd4)) w_state_next = S_DONE;
          else if (!w_term && !w_room)   w_state_next = S_ERROR;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 5; i++) r_len[i] <= 4'd0;
      r_cur    <= 3'd0;
      r_wr_ptr <= 4'd0;
    end else if ((r_state != S_LOAD) && i_start) begin
      for (int i = 0; i < 5; i++) r_len[i] <= 4'd0;
      r_cur    <= 3'd0;
      r_wr_ptr <= 4'd0;
    end else if (w_accept) begin
      if (w_term) begin
        r_len[r_cur] <= r_wr_ptr;
        r_wr_ptr     <= 4'd0;
        r_cur        <= r_cur + 3'd1;
      end else if (w_room) begin
        r_wr_ptr <= r_wr_ptr + 4'd1;
      end
    end
  end

  // Contents need no reset: a slot is only visible once its codon length covers it.
  always_ff @(posedge i_clk) begin
    if (w_accept && !w_term && w_room) begin
      r_store[r_cur][r_wr_ptr] <= i_nibble_in;
    end
  end

  logic [3:0] w_codon [5];
  logic [4:0] w_end;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_codon
      logic w_hit;
      assign w_hit        = (i_codon_index < r_len[gi]) && (i_codon_index < MAX_LEN_4);
      assign w_codon[gi]  = w_hit ? r_store[gi][i_codon_index] : 4'hF;
      assign w_end[gi]    = (r_len[gi] != 4'd0) && (i_codon_index == (r_len[gi] - 4'd1));
    end
  endgenerate

  assign o_codon1       = w_codon[0];
  assign o_codon2       = w_codon[1];
  assign o_codon3       = w_codon[2];
  assign o_codon4       = w_codon[3];
  assign o_codon5       = w_codon[4];
  assign o_end_of_codon = w_end;
  assign o_nibble_ready = (r_state == S_LOAD);
  assign o_done_reader  = (r_state == S_DONE);
  assign o_error        = (r_state == S_ERROR);

endmodule

// File: doc/codon_reader.md
CODON_READER -- requirements
Module: codon_reader

Interface
REQ-001 Parameter: MAX_LEN, default 8, maximum nibbles per codon (legal range 1..15).
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin loading a new codon set.
REQ-005 nibble_in  input  4  codon load data; 4'hF is the codon terminator.
REQ-006 nibble_valid  input  1  nibble_in holds a valid load nibble.
REQ-007 nibble_ready  output  1  block accepts nibble_in this cycle.
REQ-008 codon_index  input  4  nibble position the counter is addressing in all five codons.
REQ-009 codon1..codon5  output  4 each  nibble of codon K at codon_index.
REQ-010 end_of_codon  output  5  bit K-1 high when codon_index addresses the last nibble of codon K.
REQ-011 done_reader  output  1  codon set loaded and stable.
REQ-012 error  output  1  load aborted because a codon exceeded MAX_LEN.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, DONE and ERROR.
REQ-014 IDLE/DONE/ERROR with start=1 SHALL go to LOAD next cycle, clearing all five lengths, codon pointer and write pointer to 0, done_reader and error to 0.
REQ-015 start SHALL be ignored while in LOAD.
REQ-016 nibble_ready SHALL equal (state==LOAD); a nibble is accepted only when nibble_valid && nibble_ready.
REQ-017 Accepted non-F nibble with write pointer < MAX_LEN: stored at store[cur][wr_ptr]; wr_ptr increments.
REQ-018 Accepted non-F nibble with wr_ptr == MAX_LEN: go to ERROR next cycle; error=1; lengths of incomplete codons stay 0.
REQ-019 Accepted 4'hF: len[cur] <= wr_ptr, wr_ptr <= 0, cur <= cur+1.
REQ-020 Accepted 4'hF when cur==4: also go to DONE; done_reader=1 on the following cycle.
REQ-021 4'hF accepted with wr_ptr==0 SHALL produce a disabled codon (length 0).
REQ-022 codonK SHALL be store[K][codon_index] when codon_index < len[K], else 4'hF; purely combinational from codon_index (zero latency).
REQ-023 end_of_codon[K-1] SHALL be 1 iff len[K]!=0 and codon_index == len[K]-1.
REQ-024 codon_index >= MAX_LEN SHALL yield 4'hF on every codon and end_of_codon = 0.
REQ-025 In LOAD, ERROR and IDLE, codon outputs follow REQ-022/023 using current lengths (all 0 after start, so all 4'hF).
REQ-026 done_reader SHALL be 1 only in DONE; error only in ERROR.
REQ-027 Stored codons SHALL remain unchanged in DONE regardless of nibble_valid.

Reset
REQ-028 reset low SHALL immediately force state IDLE, all lengths, cur and wr_ptr to 0, nibble_ready, done_reader and error to 0; codon outputs therefore 4'hF, end_of_codon 5'b00000.
REQ-029 reset asserted mid-LOAD SHALL discard the partial load; after release the block waits in IDLE for start.

Verification
REQ-030 Load A,3,F / 2,F / 1,4,7,F / F / 5,F with valid held high -> done_reader=1 one cycle after fifth F; codon_index=0 gives codon1..5 = A,2,1,F,5, end_of_codon=5'b10010; index 1 gives 3,F,4,F,F, end_of_codon=5'b00001; index 2 gives F,F,7,F,F, end_of_codon=5'b00100.
REQ-031 Load with nibble_valid toggled every other cycle -> same stored result as REQ-030; nibbles with valid=0 ignored.
REQ-032 Codon1 = nine non-F nibbles (MAX_LEN=8) -> error=1 cycle after ninth accept, nibble_ready=0, done_reader=0; start then restarts cleanly.
REQ-033 Five consecutive 4'hF -> done_reader=1, all codons 4'hF at every index, end_of_codon=0.
REQ-034 reset pulsed low after third codon terminator -> outputs return to reset values asynchronously; new start plus full load succeeds.
REQ-035 start asserted in DONE -> LOAD next cycle, done_reader=0, all codon outputs 4'hF until reload completes.
